atom_mem_arbiter: RTL
=====================

// Module: atom_mem_arbiter
// PURPOSE
//  Sequences the single-port 192 KB system RAM/ROM array between two requesters: the Atom core
//  external bus (CPU) and the HPS download path that writes a utility image into paged-ROM slot 7.
//  The CPU has priority; download bytes are buffered in a small FIFO and written in idle slots,
//  with a starvation guard. Suppresses CPU writes to ROM-mapped addresses.
// PARAMETERS
//  ADDR_W        18        memory address width
//  DL_BASE       18'h17000 memory address of download byte 0 (slot 7)
//  DL_SIZE       4096      download window in bytes; dl_addr >= DL_SIZE is dropped
//  FIFO_DEPTH    4         download FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  8         consecutive CPU grants with FIFO full before download is forced
// PORTS
//  clk_42       in  1       system clock; all logic on rising edge
//  reset        in  1       synchronous, active-high
//  cpu_req      in  1       one-cycle access request (must not re-assert before cpu_ack)
//  cpu_we       in  1       1 = write, 0 = read; sampled with cpu_req
//  cpu_rom      in  1       access targets a ROM-mapped address; sampled with cpu_req
//  cpu_addr     in  ADDR_W  access address; sampled with cpu_req
//  cpu_wdata    in  8       write data; sampled with cpu_req
//  cpu_rdata    out 8       read data, valid while cpu_ack=1
//  cpu_ack      out 1       one-cycle completion pulse (reads and writes)
//  dl_en        in  1       download active (already synchronised to clk_42)
//  dl_wr        in  1       one-cycle byte strobe
//  dl_addr      in  25      byte offset within download image
//  dl_data      in  8       download byte
//  dl_full      out 1       FIFO count == FIFO_DEPTH (registered)
//  dl_overflow  out 1       sticky: dl_wr seen while full, or dl_addr >= DL_SIZE
//  dl_done      out 1       one-cycle pulse: dl_en low, FIFO empty, arbiter idle, after dl_en was high
//  mem_addr     out ADDR_W  registered array address
//  mem_we       out 1       registered array write enable
//  mem_din      out 8       registered array write data
//  mem_dout     in  8       array read data (address registered inside array, 1-cycle latency)
// BEHAVIOUR
//  - Reset: state IDLE, FIFO emptied, starve count 0, all outputs 0 (mem_we=0 at the reset edge).
//    Reset mid-access abandons it: no cpu_ack, no further write.
//  - cpu_req is latched into cpu_pend (with we/rom/addr/wdata) whenever seen; serviced from IDLE.
//  - FSM states IDLE, CPU_ISSUE, CPU_DATA, DL_ISSUE. Decision in IDLE (pending = cpu_pend or cpu_req):
//      pending and not (FIFO full and starve==STARVE_LIMIT) -> CPU_ISSUE: drive mem_addr=cpu_addr,
//        mem_din=cpu_wdata, mem_we=cpu_we & ~cpu_rom; clear cpu_pend; starve+1 if FIFO full, else 0.
//      else FIFO non-empty -> DL_ISSUE: pop head, mem_addr=DL_BASE+offset, mem_din=data,
//        mem_we=1; starve=0.
//      else stay IDLE, mem_we=0.
//  - CPU_ISSUE -> CPU_DATA (mem_we<=0). CPU_DATA -> IDLE with cpu_rdata<=mem_dout, cpu_ack<=1.
//    Latency: cpu_req sampled at edge E0 -> cpu_ack high after E2 (3 cycles) when uncontended;
//    worst case +1 cycle if a DL_ISSUE is in flight.
//  - DL_ISSUE -> IDLE (mem_we<=0). Each download write occupies exactly one cycle.
//  - Suppressed ROM write still completes normally with cpu_ack; array contents unchanged.
//  - FIFO: push on dl_wr & dl_en & ~full & dl_addr<DL_SIZE; store dl_addr[11:0] and data.
//    Push+pop same cycle: count unchanged. Rejected push sets dl_overflow (cleared by reset or
//    rising dl_en). dl_wr while dl_en=0 ignored. Pointers wrap modulo FIFO_DEPTH.
//  - Mem address sum DL_BASE+offset truncated to ADDR_W.
// TESTING
//  - Read: array[0x0123]=0x5A; cpu_req read 0x0123 -> mem_addr=0x0123 after E0, cpu_ack+cpu_rdata=0x5A after E2.
//  - ROM guard: cpu_req write 0x0F000 data 0x11 cpu_rom=1 -> cpu_ack after E2, mem_we never 1, array unchanged.
//  - Download: dl_en=1, 3 bytes offs 0..2 = AA,BB,CC, no CPU traffic -> writes 0x17000..0x17002, dl_done one cycle after dl_en falls & empty.
//  - Contention: cpu_req every 3 cycles, dl_wr every cycle -> dl_full asserts, after 8 CPU grants one
//    DL_ISSUE forced; 5th back-to-back dl_wr while full sets dl_overflow; all CPU reads correct.
//  - Bounds: dl_addr=4096 with dl_wr -> no write, dl_overflow=1; dl_addr=4095 -> write to 0x17FFF.
//  - Reset during CPU_ISSUE of a read -> no cpu_ack, mem_we=0, FIFO count 0 next cycle; next req served normally.

Source files
------------

// File: rtl/atom_mem_arbiter.sv
// atom_mem_arbiter
// Shares the single-port system RAM/ROM array between the Atom CPU bus and the
// HPS download path that writes a utility image into paged-ROM slot 7.
// The CPU wins arbitration. Download bytes wait in a small FIFO and are written
// in idle slots. A starvation counter forces one download write when the FIFO
// has been full for too long. CPU writes to ROM-mapped addresses are dropped,
// but they still complete with an acknowledge.
module atom_mem_arbiter #(
  parameter int                ADDR_W       = 18,
  parameter logic [ADDR_W-1:0] DL_BASE      = 18'h17000,
  parameter int                DL_SIZE      = 4096,
  parameter int                FIFO_DEPTH   = 4,
  parameter int                STARVE_LIMIT = 8
) (
  input  logic              clk_42,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_rom,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              dl_en,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_full,
  output logic              dl_overflow,
  output logic              dl_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  localparam int OFF_W = $clog2(DL_SIZE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CPU_ISSUE = 2'd1;
  localparam logic [1:0] CPU_DATA  = 2'd2;
  localparam logic [1:0] DL_ISSUE  = 2'd3;

  logic [1:0]        state;
  logic              cpu_pend;
  logic              pend_we;
  logic              pend_rom;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_wdata;
  logic [SW-1:0]     starve_cnt;

  logic [OFF_W-1:0]  fifo_off [FIFO_DEPTH];
  logic [7:0]        fifo_dat [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic              dl_en_q;
  logic              dl_seen;

  logic              pending;
  logic              starved;
  logic              fifo_empty;
  logic              grant_cpu;
  logic              grant_dl;
  logic              in_range;
  logic              push;
  logic              reject;
  logic              done_cond;
  logic              sel_we;
  logic              sel_rom;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  // A request arriving this cycle is used directly so that an idle arbiter does not lose a cycle.
  always_comb begin
    pending    = cpu_pend | cpu_req;
    sel_we     = cpu_req ? cpu_we    : pend_we;
    sel_rom    = cpu_req ? cpu_rom   : pend_rom;
    sel_addr   = cpu_req ? cpu_addr  : pend_addr;
    sel_wdata  = cpu_req ? cpu_wdata : pend_wdata;
    fifo_empty = (fifo_count == '0);
    starved    = dl_full & (starve_cnt == SW'(STARVE_LIMIT));
    grant_cpu  = (state == IDLE) & pending & ~starved;
    grant_dl   = (state == IDLE) & ~grant_cpu & ~fifo_empty;
    in_range   = (dl_addr < 25'(DL_SIZE));
    push       = dl_wr & dl_en & ~dl_full & in_range;
    reject     = dl_wr & dl_en & (dl_full | ~in_range);
    done_cond  = dl_seen & ~dl_en & fifo_empty & (state == IDLE);
    case ({push, grant_dl})
      2'b10:   count_next = fifo_count + CW'(1);
      2'b01:   count_next = fifo_count - CW'(1);
      default: count_next = fifo_count;
    endcase
  end

  // The main sequencer. It owns the array port, the CPU completion and the starvation count.
  always_ff @(posedge clk_42) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      starve_cnt <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state      <= CPU_ISSUE;
            mem_addr   <= sel_addr;
            mem_din    <= sel_wdata;
            mem_we     <= sel_we & ~sel_rom;
            starve_cnt <= dl_full ? starve_cnt + SW'(1) : '0;
          end else if (grant_dl) begin
            state      <= DL_ISSUE;
            mem_addr   <= DL_BASE + ADDR_W'(fifo_off[rd_ptr]);
            mem_din    <= fifo_dat[rd_ptr];
            mem_we     <= 1'b1;
            starve_cnt <= '0;
          end else begin
            mem_we <= 1'b0;
          end
        end
        CPU_ISSUE: begin
          state  <= CPU_DATA;
          mem_we <= 1'b0;
        end
        CPU_DATA: begin
          state     <= IDLE;
          cpu_rdata <= mem_dout;
          cpu_ack   <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Hold a CPU request that could not be served at once, together with its attributes.
  always_ff @(posedge clk_42) begin
    if (reset) begin
      cpu_pend   <= 1'b0;
      pend_we    <= 1'b0;
      pend_rom   <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
    end else begin
      cpu_pend <= pending & ~grant_cpu;
      if (cpu_req) begin
        pend_we    <= cpu_we;
        pend_rom   <= cpu_rom;
        pend_addr  <= cpu_addr;
        pend_wdata <= cpu_wdata;
      end
    end
  end

  // FIFO storage. It has no reset because only the pointers decide what is valid.
  always_ff @(posedge clk_42) begin
    if (push) begin
      fifo_off[wr_ptr] <= dl_addr[OFF_W-1:0];
      fifo_dat[wr_ptr] <= dl_data;
    end
  end

  // FIFO pointers and occupancy. The registered full flag follows the next count.
  always_ff @(posedge clk_42) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      dl_full    <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (grant_dl) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_next;
      dl_full    <= (count_next == CW'(FIFO_DEPTH));
    end
  end

  // Download status. The overflow flag is sticky until a new session starts.
  // The done pulse fires once the session has closed and everything has been written.
  always_ff @(posedge clk_42) begin
    if (reset) begin
      dl_en_q     <= 1'b0;
      dl_seen     <= 1'b0;
      dl_overflow <= 1'b0;
      dl_done     <= 1'b0;
    end else begin
      dl_en_q <= dl_en;
      dl_done <= done_cond;
      if (dl_en)          dl_seen <= 1'b1;
      else if (done_cond) dl_seen <= 1'b0;
      if (reject)                 dl_overflow <= 1'b1;
      else if (dl_en & ~dl_en_q)  dl_overflow <= 1'b0;
    end
  end

endmodule
